// File: rtl/mem_access.sv
// mem_access: memory stage driving a single-outstanding req/ack data bus; MEM_BUS_TIMEOUT_EN adds a bus watchdog.
package mem_access_pkg;
    localparam int XLEN = 32;
    typedef enum logic [2:0] {UNIT_ALU, UNIT_BRANCH, UNIT_MEM, UNIT_AMO, UNIT_CSR} unit_t;
    typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W} op_size_t;
    typedef struct packed {
        unit_t      unit;
        logic       is_store;
        logic       is_unsigned;
        op_size_t   op_size;
        logic [4:0] rd;
    } decode_t;
    typedef struct packed {
        logic            valid;
        logic [3:0]      cause;
        logic [XLEN-1:0] value;
    } except_t;
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        decode_t         decode;
        except_t         except;
    } issued_instr_t;
    localparam logic [3:0] CAUSE_LOAD_ACCESS_FAULT = 4'd5;
    localparam logic [3:0] CAUSE_STORE_ACCESS_FAULT = 4'd7;
endpackage

`define EXCEPT_LOAD_ACCESS_FAULT(a) '{valid: 1'b1, cause: mem_access_pkg::CAUSE_LOAD_ACCESS_FAULT, value: (a)}
`define EXCEPT_STORE_ACCESS_FAULT(a) '{valid: 1'b1, cause: mem_access_pkg::CAUSE_STORE_ACCESS_FAULT, value: (a)}

module mem_access
    import mem_access_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_stall,
    input  issued_instr_t   i_instr,
    input  logic [XLEN-1:0] i_data,
    input  logic [XLEN-1:0] i_data_rs2,
    output logic            o_stall,
    output issued_instr_t   o_instr,
    output logic [XLEN-1:0] o_data,
    output logic            o_dbus_req,
    output logic            o_dbus_we,
    output logic [XLEN-1:0] o_dbus_addr,
    output logic [3:0]      o_dbus_be,
    output logic [XLEN-1:0] o_dbus_wdata,
    input  logic            i_dbus_ack,
    input  logic [XLEN-1:0] i_dbus_rdata,
    input  logic [31:0]     i_log_fd
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;
    state_t state, state_n;
    logic mem_op, tmo, faulted, upd, uns;
    logic [1:0] lo;
    op_size_t sz;
    except_t fault;
    logic [3:0] be_n;
    logic [XLEN-1:0] wdata_n, shifted, load_val, hold, n_data;
    issued_instr_t n_instr;

    assign mem_op = i_instr.valid & ~i_instr.except.valid & (i_instr.decode.unit == UNIT_MEM);
    assign o_stall = i_stall | (mem_op & state != DONE) | state == DRAIN;

    assign be_n = i_instr.decode.op_size == SIZE_B ? 4'b0001 << i_data[1:0] :
                  i_instr.decode.op_size == SIZE_H ? 4'b0011 << i_data[1:0] : 4'b1111;
    assign wdata_n = i_instr.decode.op_size == SIZE_B ? {(XLEN/8){i_data_rs2[7:0]}} :
                     i_instr.decode.op_size == SIZE_H ? {(XLEN/16){i_data_rs2[15:0]}} : i_data_rs2;
    assign shifted = i_dbus_rdata >> {lo, 3'b000};
    assign load_val = sz == SIZE_B ? {{(XLEN-8){~uns & shifted[7]}}, shifted[7:0]} :
                      sz == SIZE_H ? {{(XLEN-16){~uns & shifted[15]}}, shifted[15:0]} : shifted;

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    assign tmo = state == BUSY & ~i_dbus_ack & (cnt == CW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush || i_dbus_ack || state != BUSY)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
        if (i_rst || (state == IDLE && state_n == BUSY))
            faulted <= 1'b0;
        else if (tmo && !i_flush)
            faulted <= 1'b1;
        if (tmo && o_dbus_we)
            fault <= `EXCEPT_STORE_ACCESS_FAULT(i_data);
        else if (tmo)
            fault <= `EXCEPT_LOAD_ACCESS_FAULT(i_data);
    end
`else
    assign tmo = 1'b0;
    assign faulted = 1'b0;
    assign fault = '0;
`endif

    always_ff @(posedge i_clk)
        state <= i_rst ? IDLE : state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (mem_op && !i_flush) state_n = BUSY;
            BUSY:  if (i_dbus_ack || tmo) state_n = i_flush ? IDLE : DONE;
                   else if (i_flush) state_n = DRAIN;
            DONE:  if (i_flush || !i_stall) state_n = IDLE;
            DRAIN: if (i_dbus_ack) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Bus fields stay frozen from launch until ack so the slave sees a stable request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_dbus_req   <= 1'b0;
            o_dbus_we    <= 1'b0;
            o_dbus_be    <= '0;
            o_dbus_addr  <= '0;
            o_dbus_wdata <= '0;
        end else if (state == IDLE && state_n == BUSY) begin
            o_dbus_req   <= 1'b1;
            o_dbus_we    <= i_instr.decode.is_store;
            o_dbus_be    <= be_n;
            o_dbus_addr  <= {i_data[XLEN-1:2], 2'b00};
            o_dbus_wdata <= wdata_n;
            lo           <= i_data[1:0];
            sz           <= i_instr.decode.op_size;
            uns          <= i_instr.decode.is_unsigned;
        end else if (i_dbus_ack || tmo) begin
            o_dbus_req   <= 1'b0;
        end
    end

    always_ff @(posedge i_clk)
        if (state == BUSY && i_dbus_ack) hold <= load_val;

    always_comb begin
        upd = 1'b0;
        n_instr = o_instr;
        n_data = o_data;
        if (i_flush) begin
            upd = 1'b1;
            n_instr = '0;
            n_data = '0;
        end else if (!i_stall) begin
            upd = 1'b1;
            if (state == DONE) begin
                n_instr = i_instr;
                if (faulted) n_instr.except = fault;
                n_data = (o_dbus_we || faulted) ? i_data : hold;
            end else if (state == IDLE && !mem_op) begin
                n_instr = i_instr;
                n_data = i_data;
            end else begin
                n_instr = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_instr <= '0;
            o_data  <= '0;
        end else if (upd) begin
            o_instr <= n_instr;
            o_data  <= n_data;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge i_clk)
        if (!i_rst && upd && i_log_fd != 0)
            $display("[MEM] valid=%0d pc=%h addr=%h data=%h", n_instr.valid, n_instr.pc, i_data, n_data);
`endif
endmodule
